// File: rtl/imem_loader.sv
// Instruction-memory program loader: consumes a length-prefixed little-endian byte
// stream, writes 32-bit words to instruction memory and holds the core until done.
module imem_loader #(
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned DEPTH_WORDS = 32768
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_start,
  input  logic              i_byte_valid,
  input  logic [7:0]        i_byte_data,
  output logic              o_byte_ready,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [31:0]       o_wr_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic              o_cpu_hold
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANE_W = 24;
  localparam int unsigned BIDX_W = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_count;
  logic [CNT_W-1:0]    r_word_idx;
  logic [BIDX_W-1:0]   r_byte_idx;
  logic [LANE_W-1:0]   r_lanes;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data;
  logic                r_busy;
  logic                r_done;
  logic                r_error;
  logic                r_cpu_hold;

  state_t              w_state_nxt;
  logic [CNT_W-1:0]    w_count_nxt;
  logic [CNT_W-1:0]    w_word_idx_nxt;
  logic [BIDX_W-1:0]   w_byte_idx_nxt;
  logic [LANE_W-1:0]   w_lanes_nxt;
  logic                w_wr_en_nxt;
  logic [ADDR_W-1:0]   w_wr_addr_nxt;
  logic [DATA_W-1:0]   w_wr_data_nxt;
  logic                w_busy_nxt;
  logic                w_done_nxt;
  logic                w_error_nxt;
  logic                w_cpu_hold_nxt;
  logic                w_xfer;
  logic [CNT_W-1:0]    w_hdr_n;
  logic [CNT_W-1:0]    w_word_idx_inc;

  // Stream handshake is a pure decode of the header/payload states
  assign o_byte_ready   = (r_state == S_HDR0) || (r_state == S_HDR1) || (r_state == S_DATA);
  assign w_xfer         = i_byte_valid & o_byte_ready;
  assign w_hdr_n        = {i_byte_data, r_count[BYTE_W-1:0]};
  assign w_word_idx_inc = r_word_idx + CNT_W'(1);

  // State register and all registered outputs
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_word_idx <= '0;
      r_byte_idx <= '0;
      r_lanes    <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_cpu_hold <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_word_idx <= w_word_idx_nxt;
      r_byte_idx <= w_byte_idx_nxt;
      r_lanes    <= w_lanes_nxt;
      r_wr_en    <= w_wr_en_nxt;
      r_wr_addr  <= w_wr_addr_nxt;
      r_wr_data  <= w_wr_data_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_error    <= w_error_nxt;
      r_cpu_hold <= w_cpu_hold_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt    = r_state;
    w_count_nxt    = r_count;
    w_word_idx_nxt = r_word_idx;
    w_byte_idx_nxt = r_byte_idx;
    w_lanes_nxt    = r_lanes;
    w_wr_en_nxt    = 1'b0;
    w_wr_addr_nxt  = r_wr_addr;
    w_wr_data_nxt  = r_wr_data;

    unique case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (i_start) begin
          w_state_nxt = S_HDR0;
        end
      end
      S_HDR0: begin
        if (w_xfer) begin
          w_count_nxt = CNT_W'(i_byte_data);
          w_state_nxt = S_HDR1;
        end
      end
      S_HDR1: begin
        if (w_xfer) begin
          w_count_nxt    = w_hdr_n;
          w_word_idx_nxt = '0;
          w_byte_idx_nxt = '0;
          if (w_hdr_n == '0) begin
            w_state_nxt = S_DONE;
          end else if (32'(w_hdr_n) > DEPTH_WORDS) begin
            w_state_nxt = S_ERROR;
          end else begin
            w_state_nxt = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (w_xfer) begin
          w_byte_idx_nxt = r_byte_idx + BIDX_W'(1);
          unique case (r_byte_idx)
            2'd0: w_lanes_nxt[7:0]   = i_byte_data;
            2'd1: w_lanes_nxt[15:8]  = i_byte_data;
            2'd2: w_lanes_nxt[23:16] = i_byte_data;
            default: begin
              // Final byte goes straight into the write word; strobe shows during WRITE
              w_wr_en_nxt   = 1'b1;
              w_wr_addr_nxt = ADDR_W'({r_word_idx, 2'b00});
              w_wr_data_nxt = {i_byte_data, r_lanes};
              w_state_nxt   = S_WRITE;
            end
          endcase
        end
      end
      S_WRITE: begin
        w_word_idx_nxt = w_word_idx_inc;
        w_byte_idx_nxt = '0;
        if (w_word_idx_inc == r_count) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_DATA;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt     = (w_state_nxt == S_HDR0) || (w_state_nxt == S_HDR1) ||
                     (w_state_nxt == S_DATA) || (w_state_nxt == S_WRITE);
    w_done_nxt     = (w_state_nxt == S_DONE);
    w_error_nxt    = (w_state_nxt == S_ERROR);
    w_cpu_hold_nxt = (w_state_nxt != S_DONE);
  end

  assign o_wr_en    = r_wr_en;
  assign o_wr_addr  = r_wr_addr;
  assign o_wr_data  = r_wr_data;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_error    = r_error;
  assign o_cpu_hold = r_cpu_hold;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream program loader; the write side of the instruction memory.
- Receives a length-prefixed byte stream (e.g. from the UART receiver), assembles little-endian 32-bit instructions, and issues single-cycle word writes into instruction memory at word-aligned byte addresses.
- Holds the core in reset (cpu_hold) until a load completes.

Parameters:
- ADDR_W, 17, byte-address width of instruction memory; word index is ADDR_W-2 bits.
- DEPTH_WORDS, 32768, capacity in 32-bit words; header counts above this are rejected.

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset_n  input  1  synchronous, active-low reset.
- start  input  1  begin a load; sampled only in IDLE, DONE or ERROR.
- byte_valid  input  1  byte_data holds a valid byte.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader accepts a byte this cycle; transfer occurs when byte_valid & byte_ready.
- wr_en  output  1  instruction-memory write strobe, one cycle per word.
- wr_addr  output  ADDR_W  byte address of the write, bits [1:0] always 0.
- wr_data  output  32  instruction word.
- busy  output  1  load in progress.
- done  output  1  load completed successfully; sticky.
- error  output  1  header rejected; sticky.
- cpu_hold  output  1  keep processor in reset; deasserted only in DONE.

Behaviour:
- All outputs are registered except byte_ready, which decodes from state.
- Reset (reset_n=0 at posedge), including mid-load:
  - state=IDLE; byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, error=0, cpu_hold=1.
  - Internal count, word_idx and byte_idx are cleared; any partial word is discarded and no write is issued.
- Stream format:
  - Two header bytes, N[7:0] then N[15:8].
  - Then 4*N payload bytes; each word is b0 in [7:0], b1 in [15:8], b2 in [23:16], b3 in [31:24].
- States and transitions:
  - IDLE: byte_ready=0. start=1 -> HDR0; busy=1 from the next cycle.
  - HDR0: byte_ready=1. On transfer, capture N[7:0] -> HDR1.
  - HDR1: byte_ready=1. On transfer, capture N[15:8] and evaluate the full 16-bit N:
    - N==0 -> DONE, no writes.
    - N>DEPTH_WORDS -> ERROR.
    - Otherwise -> DATA with word_idx=0, byte_idx=0.
  - DATA: byte_ready=1. On transfer, store the byte in lane byte_idx and increment byte_idx. The transfer with byte_idx==3 -> WRITE.
  - WRITE: byte_ready=0 (stream stalled).
    - Registered outputs wr_en=1, wr_addr={word_idx,2'b00}, wr_data=assembled word are visible in the cycle after entering WRITE, for exactly 1 cycle.
    - word_idx increments.
    - If word_idx+1==N -> DONE, else -> DATA with byte_idx=0.
  - DONE: busy=0, done=1, cpu_hold=0. start=1 -> HDR0; done clears and cpu_hold=1 the next cycle.
  - ERROR: busy=0, error=1, cpu_hold=1. start=1 -> HDR0; error clears the next cycle.
- start while busy (HDR0/HDR1/DATA/WRITE) is ignored.
- byte_valid with byte_ready=0 is not consumed; the source holds the byte.
- Gaps in byte_valid stall the FSM indefinitely; there is no timeout.
- Minimum throughput: 5 cycles per word (4 transfers + 1 WRITE).
- wr_data and wr_addr hold their last values when wr_en=0.
- Widths: N, word_idx and count are 16 bits. The N==DEPTH_WORDS (32768) boundary is legal; the last write is to address 17'h1FFFC.
- No address wrap-around can occur because N is bounded before DATA.

Test Plan:
- Reset, then start; stream 02 00, 93 00 20 00, 13 01 30 00 with byte_valid held high -> wr_en pulses twice: addr 0 with data 32'h00200093, then addr 4 with data 32'h00300113. done=1, cpu_hold=0, busy=0; exactly 2 + 8 byte transfers occur.
- Header 00 00 -> DONE with no wr_en pulse, done=1, cpu_hold=0.
- Header 01 80 (N=32769) -> ERROR, error=1, cpu_hold=1, no writes. A following start plus valid 1-word stream -> error clears and done=1.
- Randomised byte_valid gaps (valid ~40%) on a 3-word load -> identical writes to the gap-free run. byte_ready=0 during every WRITE cycle; no byte lost or duplicated.
- reset_n=0 for one cycle after 2 payload bytes of word 1 -> all outputs at reset values. A fresh load of 1 word (DEADBEEF bytes EF BE AD DE) writes 32'hDEADBEEF at addr 0 only.
- start pulsed during DATA -> ignored, load completes normally. start in DONE -> cpu_hold returns to 1 and a second load overwrites from addr 0.
